// File: rtl/aes_job_arbiter.sv
// aes_job_arbiter: round-robin front-end sharing one AES enc/dec engine pair.
// Latches winner operands, issues start, waits done/watchdog, returns result.
module aes_job_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int TIMEOUT = 32,
  parameter int IDW     = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NUM_REQ-1:0]     req_valid,
  input  logic [NUM_REQ-1:0]     req_mode,
  input  logic [128*NUM_REQ-1:0] req_text,
  input  logic [128*NUM_REQ-1:0] req_key,
  output logic [NUM_REQ-1:0]     req_ready,
  output logic                   eng_start,
  output logic                   eng_mode,
  output logic [127:0]           eng_text,
  output logic [127:0]           eng_key,
  input  logic                   eng_done,
  input  logic [127:0]           eng_result,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [IDW-1:0]         rsp_id,
  output logic [127:0]           rsp_data,
  output logic                   rsp_err,
  output logic                   busy
);

  localparam int WDW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    RESP
  } state_e;

  state_e         state_q, state_d;
  logic [IDW-1:0] rr_ptr_q, rr_ptr_d;
  logic [WDW-1:0] wdog_q, wdog_d;
  logic [127:0]   eng_text_q, eng_text_d;
  logic [127:0]   eng_key_q, eng_key_d;
  logic           eng_mode_q, eng_mode_d;
  logic [127:0]   rsp_data_q, rsp_data_d;
  logic [IDW-1:0] rsp_id_q, rsp_id_d;
  logic           rsp_err_q, rsp_err_d;
  logic           eng_start_q, eng_start_d;
  logic           rsp_valid_q, rsp_valid_d;
  logic           busy_q, busy_d;

  logic           found;
  logic [IDW-1:0] win;
  logic [IDW-1:0] next_ptr;

  // first pending requester at or above rr_ptr, wrapping
  always_comb begin
    int idx;
    idx   = 0;
    found = 1'b0;
    win   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = (int'(rr_ptr_q) + k) % NUM_REQ;
      if (!found && req_valid[idx]) begin
        found = 1'b1;
        win   = IDW'(idx);
      end
    end
  end

  assign next_ptr = (rsp_id_q == IDW'(NUM_REQ - 1))
                  ? '0 : rsp_id_q + 1'b1;

  // accept pulse is gated by rst_n so it drops with an async reset
  assign req_ready = (rst_n && state_q == IDLE && found)
                   ? ({{(NUM_REQ-1){1'b0}}, 1'b1} << win)
                   : '0;

  // next-state and registered-output computation
  always_comb begin
    int sel;
    sel         = int'(win) * 128;
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    wdog_d      = wdog_q;
    eng_text_d  = eng_text_q;
    eng_key_d   = eng_key_q;
    eng_mode_d  = eng_mode_q;
    rsp_data_d  = rsp_data_q;
    rsp_id_d    = rsp_id_q;
    rsp_err_d   = rsp_err_q;
    unique case (state_q)
      IDLE: begin
        if (found) begin
          state_d    = ISSUE;
          eng_text_d = req_text[sel +: 128];
          eng_key_d  = req_key[sel +: 128];
          eng_mode_d = req_mode[win];
          rsp_id_d   = win;
        end
      end
      ISSUE: begin
        wdog_d  = '0;
        state_d = WAIT;
      end
      WAIT: begin
        wdog_d = wdog_q + 1'b1;
        if (eng_done) begin
          rsp_data_d = eng_result;
          rsp_err_d  = 1'b0;
          state_d    = RESP;
        end else if (wdog_q == WDW'(TIMEOUT - 1)) begin
          rsp_data_d = '0;
          rsp_err_d  = 1'b1;
          state_d    = RESP;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          state_d  = IDLE;
          rr_ptr_d = next_ptr;
        end
      end
      default: state_d = IDLE;
    endcase
    eng_start_d = (state_d == ISSUE);
    rsp_valid_d = (state_d == RESP);
    busy_d      = (state_d != IDLE);
  end

  // state and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      rr_ptr_q    <= '0;
      wdog_q      <= '0;
      eng_text_q  <= '0;
      eng_key_q   <= '0;
      eng_mode_q  <= 1'b0;
      rsp_data_q  <= '0;
      rsp_id_q    <= '0;
      rsp_err_q   <= 1'b0;
      eng_start_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      wdog_q      <= wdog_d;
      eng_text_q  <= eng_text_d;
      eng_key_q   <= eng_key_d;
      eng_mode_q  <= eng_mode_d;
      rsp_data_q  <= rsp_data_d;
      rsp_id_q    <= rsp_id_d;
      rsp_err_q   <= rsp_err_d;
      eng_start_q <= eng_start_d;
      rsp_valid_q <= rsp_valid_d;
      busy_q      <= busy_d;
    end
  end

  assign eng_start = eng_start_q;
  assign eng_mode  = eng_mode_q;
  assign eng_text  = eng_text_q;
  assign eng_key   = eng_key_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_id    = rsp_id_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_err   = rsp_err_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_aes_job_arbiter.sv
// tb_aes_job_arbiter: scenario tasks against a behavioural engine stub
// and a round-robin reference model.
module tb_aes_job_arbiter;

  localparam int N   = 4;
  localparam int TO  = 32;
  localparam int IDW = 2;

  localparam logic [127:0] K0 = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] P0 = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] C0 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

  logic           clk = 1'b0;
  logic           rst_n;
  logic [N-1:0]   req_valid;
  logic [N-1:0]   req_mode;
  logic [128*N-1:0] req_text;
  logic [128*N-1:0] req_key;
  logic [N-1:0]   req_ready;
  logic           eng_start;
  logic           eng_mode;
  logic [127:0]   eng_text;
  logic [127:0]   eng_key;
  logic           eng_done;
  logic [127:0]   eng_result;
  logic           rsp_valid;
  logic           rsp_ready;
  logic [IDW-1:0] rsp_id;
  logic [127:0]   rsp_data;
  logic           rsp_err;
  logic           busy;

  int total = 0;
  int bad   = 0;
  int mptr  = 0;

  int eng_lat  = 13;
  bit eng_mute = 1'b0;
  bit eng_spur = 1'b0;

  aes_job_arbiter #(.NUM_REQ(N), .TIMEOUT(TO), .IDW(IDW)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_mode(req_mode),
    .req_text(req_text), .req_key(req_key),
    .req_ready(req_ready),
    .eng_start(eng_start), .eng_mode(eng_mode),
    .eng_text(eng_text), .eng_key(eng_key),
    .eng_done(eng_done), .eng_result(eng_result),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_id(rsp_id), .rsp_data(rsp_data),
    .rsp_err(rsp_err), .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // stand-in for the AES cores: known vector pair, otherwise a keyed mix
  function automatic logic [127:0] engine_fn(
    input logic m, input logic [127:0] t, input logic [127:0] k);
    if (!m && t == P0 && k == K0) return C0;
    if (m && t == C0 && k == K0) return P0;
    return t ^ {k[63:0], k[127:64]} ^ {128{m}};
  endfunction

  function automatic int model_pick(input logic [N-1:0] mask, input int ptr);
    for (int k = 0; k < N; k++)
      if (mask[(ptr + k) % N]) return (ptr + k) % N;
    return -1;
  endfunction

  // engine stub: fixed latency after start, optional mute/spurious pulses
  int           eng_cnt;
  logic [127:0] eng_pend;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      eng_cnt    <= 0;
      eng_done   <= 1'b0;
      eng_result <= '0;
      eng_pend   <= '0;
    end else begin
      eng_done   <= 1'b0;
      eng_result <= rnd128();
      if (eng_start) begin
        eng_cnt  <= eng_lat;
        eng_pend <= engine_fn(eng_mode, eng_text, eng_key);
      end else if (eng_cnt > 0) begin
        if (eng_cnt == 1 && !eng_mute) begin
          eng_done   <= 1'b1;
          eng_result <= eng_pend;
        end
        eng_cnt <= eng_cnt - 1;
      end else if (eng_spur) begin
        eng_done <= 1'($urandom % 2);
      end
    end
  end

  // engine operands must not move while an op is in flight
  logic [127:0] h_text, h_key;
  logic         h_mode;
  always @(negedge clk) begin
    if (rst_n && busy) begin
      if (eng_start) begin
        h_text = eng_text;
        h_key  = eng_key;
        h_mode = eng_mode;
      end else begin
        total++;
        if (eng_text !== h_text || eng_key !== h_key || eng_mode !== h_mode) begin
          bad++;
          $display("FAIL operand_hold text=%h key=%h mode=%b want text=%h key=%h mode=%b",
                   eng_text, eng_key, eng_mode, h_text, h_key, h_mode);
        end
      end
    end
  end

  task automatic set_req(input int i, input bit v, input bit m,
                         input logic [127:0] t, input logic [127:0] k);
    req_valid[i]          = v;
    req_mode[i]           = m;
    req_text[128*i +: 128] = t;
    req_key[128*i +: 128]  = k;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // waits for rsp_valid from the current negedge, tallying what it sees
  task automatic wait_rsp(output int starts, output int wc,
                          output int rrs, output bit to);
    starts = 0; wc = 0; rrs = 0; to = 1'b1;
    for (int c = 0; c < 200; c++) begin
      if (rsp_valid) begin to = 1'b0; break; end
      if (eng_start) starts++;
      else if (busy) wc++;
      if (req_ready != '0) rrs++;
      @(negedge clk);
    end
  endtask

  // waits for a grant, checking at negedge+1 so the comb accept has settled
  task automatic wait_grant(output bit got);
    got = 1'b0;
    for (int c = 0; c < 60; c++) begin
      #1;
      if (req_ready != '0) begin got = 1'b1; break; end
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; rsp_ready = 1'b0;
    req_valid = 4'b0101; req_mode = '0; req_text = '0; req_key = '0;
    #12;
    total++;
    if (busy !== 1'b0 || rsp_valid !== 1'b0 || eng_start !== 1'b0 || req_ready !== '0) begin
      bad++;
      $display("FAIL reset_ctrl busy=%b rsp_valid=%b eng_start=%b req_ready=%b want 0",
               busy, rsp_valid, eng_start, req_ready);
    end
    total++;
    if (eng_text !== '0 || eng_key !== '0 || eng_mode !== 1'b0 ||
        rsp_data !== '0 || rsp_id !== '0 || rsp_err !== 1'b0) begin
      bad++;
      $display("FAIL reset_data text=%h key=%h mode=%b data=%h id=%0d err=%b want 0",
               eng_text, eng_key, eng_mode, rsp_data, rsp_id, rsp_err);
    end
    @(negedge clk);
    req_valid = '0;
    rst_n = 1'b1;
    mptr = 0;
  endtask

  task automatic test_single_encrypt();
    int st, wc, rrs; bit to;
    @(negedge clk);
    set_req(1, 1'b1, 1'b0, P0, K0);
    #1;
    total++;
    if (req_ready !== 4'b0010) begin
      bad++; $display("FAIL enc_grant got=%b want=0010", req_ready);
    end
    @(negedge clk);
    req_valid = '0;
    wait_rsp(st, wc, rrs, to);
    total++;
    if (to || st != 1 || rrs != 0) begin
      bad++; $display("FAIL enc_flow timeout=%b starts=%0d ready_pulses=%0d want 0/1/0",
                      to, st, rrs);
    end
    total++;
    if (rsp_id !== 2'd1 || rsp_data !== C0 || rsp_err !== 1'b0) begin
      bad++; $display("FAIL enc_rsp id=%0d data=%h err=%b want 1 %h 0",
                      rsp_id, rsp_data, rsp_err, C0);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    total++;
    if (rsp_valid !== 1'b0 || busy !== 1'b0) begin
      bad++; $display("FAIL enc_drop rsp_valid=%b busy=%b want 0 0", rsp_valid, busy);
    end
    mptr = 2;
  endtask

  task automatic test_decrypt();
    int st, wc, rrs; bit to;
    set_req(2, 1'b1, 1'b1, C0, K0);
    #1;
    total++;
    if (req_ready !== 4'b0100) begin
      bad++; $display("FAIL dec_grant got=%b want=0100", req_ready);
    end
    @(negedge clk);
    req_valid = '0;
    total++;
    if (eng_mode !== 1'b1 || eng_start !== 1'b1) begin
      bad++; $display("FAIL dec_issue mode=%b start=%b want 1 1", eng_mode, eng_start);
    end
    wait_rsp(st, wc, rrs, to);
    total++;
    if (to || rsp_id !== 2'd2 || rsp_data !== P0 || rsp_err !== 1'b0) begin
      bad++; $display("FAIL dec_rsp timeout=%b id=%0d data=%h err=%b want 2 %h 0",
                      to, rsp_id, rsp_data, rsp_err, P0);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    mptr = 3;
  endtask

  task automatic test_fairness();
    int st, wc, rrs, e; bit to, got;
    logic [127:0] exp_d;
    do_reset();
    mptr = 0;
    rsp_ready = 1'b1;
    for (int i = 0; i < N; i++)
      set_req(i, 1'b1, 1'($urandom % 2), rnd128(), rnd128());
    for (int j = 0; j < 8; j++) begin
      e = model_pick(4'hF, mptr);
      eng_lat = $urandom_range(1, 20);
      wait_grant(got);
      total++;
      if (!got || req_ready !== (4'b0001 << e)) begin
        bad++; $display("FAIL rr_grant job=%0d got=%b want=%b", j, req_ready, 4'b0001 << e);
      end
      exp_d = engine_fn(req_mode[e], req_text[128*e +: 128], req_key[128*e +: 128]);
      @(negedge clk);
      for (int i = 0; i < N; i++)
        set_req(i, 1'b1, 1'($urandom % 2), rnd128(), rnd128());
      wait_rsp(st, wc, rrs, to);
      total++;
      if (to || rsp_id !== IDW'(e) || rsp_data !== exp_d || rsp_err !== 1'b0) begin
        bad++; $display("FAIL rr_rsp job=%0d timeout=%b id=%0d data=%h err=%b want %0d %h 0",
                        j, to, rsp_id, rsp_data, rsp_err, e, exp_d);
      end
      total++;
      if (rrs != 0 || st != 1) begin
        bad++; $display("FAIL rr_busy job=%0d ready_pulses=%0d starts=%0d want 0 1", j, rrs, st);
      end
      mptr = (e + 1) % N;
    end
    @(negedge clk);
    req_valid = '0;
    rsp_ready = 1'b0;
    eng_lat = 13;
  endtask

  task automatic test_backpressure();
    int st, wc, rrs, e, nxt, stall_bad; bit to, got;
    logic [N-1:0] mask;
    logic [127:0] exp_d, d0;
    logic [IDW-1:0] i0;
    mask = 4'($urandom_range(1, 15));
    for (int i = 0; i < N; i++)
      set_req(i, mask[i], 1'($urandom % 2), rnd128(), rnd128());
    e = model_pick(mask, mptr);
    wait_grant(got);
    total++;
    if (!got || req_ready !== (4'b0001 << e)) begin
      bad++; $display("FAIL bp_grant got=%b want=%b", req_ready, 4'b0001 << e);
    end
    exp_d = engine_fn(req_mode[e], req_text[128*e +: 128], req_key[128*e +: 128]);
    @(negedge clk);
    wait_rsp(st, wc, rrs, to);
    total++;
    if (to || rsp_id !== IDW'(e) || rsp_data !== exp_d || rsp_err !== 1'b0) begin
      bad++; $display("FAIL bp_rsp timeout=%b id=%0d data=%h err=%b want %0d %h 0",
                      to, rsp_id, rsp_data, rsp_err, e, exp_d);
    end
    d0 = rsp_data; i0 = rsp_id;
    eng_spur = 1'b1;
    stall_bad = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (rsp_valid !== 1'b1 || rsp_data !== d0 || rsp_id !== i0 ||
          rsp_err !== 1'b0 || req_ready !== '0 || eng_start !== 1'b0)
        stall_bad++;
    end
    total++;
    if (stall_bad != 0) begin
      bad++; $display("FAIL bp_stall bad_cycles=%0d want 0 (valid=%b data=%h id=%0d)",
                      stall_bad, rsp_valid, rsp_data, rsp_id);
    end
    eng_spur = 1'b0;
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    mptr = (e + 1) % N;
    nxt = model_pick(mask, mptr);
    #1;
    total++;
    if (rsp_valid !== 1'b0 || req_ready !== (4'b0001 << nxt)) begin
      bad++; $display("FAIL bp_release rsp_valid=%b req_ready=%b want 0 %b",
                      rsp_valid, req_ready, 4'b0001 << nxt);
    end
    req_valid = '0;
  endtask

  task automatic test_timeout();
    int st, wc, rrs, r; bit to, got;
    logic [127:0] exp_d;
    @(negedge clk);
    r = $urandom_range(0, 2);
    eng_mute = 1'b1;
    set_req(r, 1'b1, 1'($urandom % 2), rnd128(), rnd128());
    wait_grant(got);
    @(negedge clk);
    req_valid = '0;
    wait_rsp(st, wc, rrs, to);
    total++;
    if (to || wc != TO || rsp_err !== 1'b1 || rsp_data !== '0 || rsp_id !== IDW'(r)) begin
      bad++; $display("FAIL to_abort timeout=%b wait=%0d err=%b data=%h id=%0d want %0d 1 0 %0d",
                      to, wc, rsp_err, rsp_data, rsp_id, TO, r);
    end
    eng_mute = 1'b0;
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    mptr = (r + 1) % N;
    req_valid = 4'hF;
    #1;
    total++;
    if (req_ready !== (4'b0001 << mptr)) begin
      bad++; $display("FAIL to_rr got=%b want=%b", req_ready, 4'b0001 << mptr);
    end
    req_valid = '0;
    // done on the very last watchdog cycle still wins
    @(negedge clk);
    r = $urandom_range(0, 2);
    eng_lat = TO - 1;
    set_req(r, 1'b1, 1'($urandom % 2), rnd128(), rnd128());
    exp_d = engine_fn(req_mode[r], req_text[128*r +: 128], req_key[128*r +: 128]);
    wait_grant(got);
    @(negedge clk);
    req_valid = '0;
    wait_rsp(st, wc, rrs, to);
    total++;
    if (to || wc != TO || rsp_err !== 1'b0 || rsp_data !== exp_d) begin
      bad++; $display("FAIL to_edge timeout=%b wait=%0d err=%b data=%h want %0d 0 %h",
                      to, wc, rsp_err, rsp_data, TO, exp_d);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    mptr = (r + 1) % N;
    eng_lat = 13;
  endtask

  task automatic test_reset_mid_wait();
    int st, wc, rrs, seen; bit to, got;
    logic [127:0] exp_d;
    @(negedge clk);
    set_req(3, 1'b1, 1'b0, rnd128(), rnd128());
    wait_grant(got);
    @(negedge clk);
    req_valid = '0;
    repeat (5) @(negedge clk);
    req_valid = 4'b0010;
    #2;
    rst_n = 1'b0;
    #1;
    total++;
    if (busy !== 1'b0 || rsp_valid !== 1'b0 || req_ready !== '0 || eng_start !== 1'b0) begin
      bad++; $display("FAIL rst_async busy=%b rsp_valid=%b req_ready=%b start=%b want 0",
                      busy, rsp_valid, req_ready, eng_start);
    end
    @(negedge clk);
    @(negedge clk);
    req_valid = '0;
    rst_n = 1'b1;
    mptr = 0;
    seen = 0;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (rsp_valid !== 1'b0 || busy !== 1'b0) seen++;
    end
    total++;
    if (seen != 0) begin
      bad++; $display("FAIL rst_no_rsp active_cycles=%0d want 0", seen);
    end
    for (int i = 0; i < N; i++)
      set_req(i, 1'b1, 1'($urandom % 2), rnd128(), rnd128());
    exp_d = engine_fn(req_mode[0], req_text[127:0], req_key[127:0]);
    #1;
    total++;
    if (req_ready !== (4'b0001 << model_pick(4'hF, mptr))) begin
      bad++; $display("FAIL rst_rr got=%b want=0001", req_ready);
    end
    @(negedge clk);
    req_valid = '0;
    wait_rsp(st, wc, rrs, to);
    total++;
    if (to || rsp_id !== 2'd0 || rsp_data !== exp_d || rsp_err !== 1'b0) begin
      bad++; $display("FAIL rst_job timeout=%b id=%0d data=%h err=%b want 0 %h 0",
                      to, rsp_id, rsp_data, rsp_err, exp_d);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single_encrypt();
    test_decrypt();
    test_fairness();
    test_backpressure();
    test_timeout();
    test_reset_mid_wait();
    repeat (2) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/aes_job_arbiter.md
Name: aes_job_arbiter

Overview:
- Shares one AES engine pair (encrypt core and decrypt core, one op in flight) between NUM_REQ requesters.
- Round-robin arbitration across requesters.
- Latches each winner's operands and holds them stable on the engine for the whole operation.
- Issues a one-cycle start, waits for the engine done pulse or a watchdog timeout, then returns the result to the winner through a valid/ready response channel.
- Sits between the instruction front-end and the encrypt/decrypt top levels.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- TIMEOUT, 32, max cycles in WAIT before the op is aborted with error (must exceed engine latency of ~13 cycles).
- IDW, 2, width of the requester id (clog2(NUM_REQ)).

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- req_valid  in  NUM_REQ  per-requester request pending.
- req_mode  in  NUM_REQ  per-requester op: 0 = encrypt, 1 = decrypt.
- req_text  in  128*NUM_REQ  per-requester plaintext/ciphertext, slice i = [128*i +: 128].
- req_key  in  128*NUM_REQ  per-requester key, same slicing.
- req_ready  out  NUM_REQ  one-hot accept pulse to the granted requester.
- eng_start  out  1  one-cycle start to the engine (drives E_int / D_int via eng_mode).
- eng_mode  out  1  latched op mode.
- eng_text  out  128  latched text operand.
- eng_key  out  128  latched key operand.
- eng_done  in  1  engine completion pulse.
- eng_result  in  128  engine output, valid when eng_done = 1.
- rsp_valid  out  1  response available.
- rsp_ready  in  1  consumer accepts response.
- rsp_id  out  IDW  requester the response belongs to.
- rsp_data  out  128  result.
- rsp_err  out  1  1 = timeout abort, rsp_data = 0.
- busy  out  1  high in any state other than IDLE.

Behaviour:
Reset values (async, rst_n low):
- State IDLE, rr_ptr = 0, wdog = 0.
- eng_text, eng_key, eng_mode, rsp_data, rsp_id, rsp_err all 0.
- eng_start, rsp_valid, req_ready, busy all 0.

State machine (IDLE, ISSUE, WAIT, RESP):

IDLE:
- Winner = first set bit of req_valid, searching upward from rr_ptr with wrap (index NUM_REQ-1 is followed by 0).
- If any bit is set: req_ready[winner] = 1 combinationally in the same cycle.
- At that edge, capture req_text/req_key/req_mode slices of the winner into eng_text/eng_key/eng_mode, set rsp_id = winner, go to ISSUE.
- If no bit is set: stay in IDLE, req_ready = 0.

ISSUE:
- eng_start = 1 for exactly this one cycle.
- wdog cleared to 0.
- Go to WAIT.

WAIT:
- wdog increments each cycle.
- If eng_done = 1: capture eng_result into rsp_data, rsp_err = 0, go to RESP. eng_done takes priority if it coincides with timeout.
- Else if wdog == TIMEOUT-1: rsp_data = 0, rsp_err = 1, go to RESP.

RESP:
- rsp_valid = 1; rsp_data, rsp_id and rsp_err are held stable.
- When rsp_ready = 1: go to IDLE and set rr_ptr = (rsp_id + 1) mod NUM_REQ.
- rsp_valid drops the cycle after the handshake.

General rules:
- eng_text, eng_key and eng_mode change only on an IDLE grant edge. They are held constant through ISSUE, WAIT and RESP, because the engine derives round keys combinationally from eng_key every round.
- eng_done outside WAIT is ignored: no state change, no data capture.
- A requester dropping req_valid after its grant has no effect on the in-flight op.
- req_valid changes during a non-IDLE state have no effect until IDLE.
- At most one req_ready bit is high at any time, and only in IDLE.
- Minimum issue-to-issue spacing: grant (IDLE) + ISSUE + engine latency + RESP (1 cycle if rsp_ready is held high) + IDLE.
- Fairness: with all requesters continuously valid, grants rotate 0, 1, 2, 3, 0, …
- Reset mid-operation returns everything to reset values immediately. No response is produced for the aborted op. The engine shares rst_n and is reset with this block.

Test Plan:
- Single encrypt: req 1 only, key 000102030405060708090a0b0c0d0e0f, text 00112233445566778899aabbccddeeff, mode 0 -> req_ready = 0010 for one cycle, one eng_start pulse, rsp_id = 1, rsp_data = 69c4e0d86a7b0430d8cdb78070b4c55a, rsp_err = 0.
- Decrypt: req 2, same key, text 69c4e0d86a7b0430d8cdb78070b4c55a, mode 1 -> eng_mode = 1, rsp_data = 00112233445566778899aabbccddeeff, rsp_id = 2.
- Fairness: all four requesters held valid for 8 jobs, rsp_ready tied 1 -> grant order 0, 1, 2, 3, 0, 1, 2, 3. eng_key/eng_text never change while busy = 1.
- Backpressure: rsp_ready held 0 for 20 cycles after rsp_valid -> rsp_valid, rsp_data and rsp_id stable. No new req_ready and no eng_start until rsp_ready = 1.
- Timeout: engine model never pulses eng_done -> exactly TIMEOUT cycles in WAIT, then rsp_err = 1, rsp_data = 0. rr_ptr still advances.
- Reset mid-WAIT: assert rst_n low 5 cycles after eng_start -> busy, rsp_valid and req_ready drop asynchronously. After release, no response appears; a new request from requester 0 is granted first (rr_ptr = 0).
